rf_rename_mp: RTL and testbench
===============================

// Module: rf_rename_mp
// PURPOSE
//  Multi-ported architectural register file with integrated rename table (busy bit + ROB tag per reg).
//  Sits between decoder (rename/read ports), ROB (in-order commit ports) and IF (jalr target read).
//  Generalises the single-issue regfile: N rename slots, M commit slots, explicit busy bit, intra-bundle bypass.
// PARAMETERS
//  XLEN           32  data width
//  REG_NUM_WIDTH  5   reg index width; REG_NUM = 1<<REG_NUM_WIDTH
//  TAG_WIDTH      4   ROB tag width (all 2^TAG_WIDTH tags legal; busy bit separate)
//  NUM_ISSUE      2   rename slots per cycle; slot 0 = oldest
//  NUM_COMMIT     2   commit slots per cycle; slot 0 = oldest
// PORTS
//  clk_in     in   1                       clock
//  rst_in     in   1                       synchronous reset, active-high
//  rdy_in     in   1                       global enable; low = hold all state
//  flush_in   in   1                       mispredict flush
//  cm_valid   in   NUM_COMMIT              commit slot valid
//  cm_rd      in   NUM_COMMIT*REG_NUM_WIDTH commit dest reg
//  cm_tag     in   NUM_COMMIT*TAG_WIDTH    commit ROB tag
//  cm_value   in   NUM_COMMIT*XLEN         commit result
//  rn_valid   in   NUM_ISSUE               rename slot valid
//  rn_rd      in   NUM_ISSUE*REG_NUM_WIDTH rename dest reg
//  rn_tag     in   NUM_ISSUE*TAG_WIDTH     tag allocated to slot
//  rn_rs1/2   in   NUM_ISSUE*REG_NUM_WIDTH source reg indices per slot
//  rn_val1/2  out  NUM_ISSUE*XLEN          source values (comb.)
//  rn_busy1/2 out  NUM_ISSUE               source pending (comb.)
//  rn_tag1/2  out  NUM_ISSUE*TAG_WIDTH     producer tag, valid when busy (comb.)
//  jalr_rs    in   REG_NUM_WIDTH           IF jalr base reg
//  jalr_value out  XLEN                    jalr base value (comb.)
//  jalr_busy  out  1                       jalr base pending; IF must stall
// BEHAVIOUR
//  State: regs[REG_NUM] XLEN, busy[REG_NUM], tag[REG_NUM]. x0: value 0, never busy, writes ignored.
//  Reset (posedge clk_in, rst_in=1): all regs=0, all busy=0, tags=0. rst_in overrides rdy_in.
//  rdy_in=0: no state change; comb outputs still valid from current state.
//  Commit (per slot c, rd!=0): regs[rd]<=value; busy[rd]<=0 iff busy && tag[rd]==cm_tag and rd not
//   renamed this cycle. Several slots same rd: highest slot's value wins.
//  Rename (per slot i, rd!=0): busy[rd]<=1, tag[rd]<=rn_tag. Same rd in several slots: highest slot wins.
//   Rename beats commit-clear on same reg same cycle.
//  flush_in=1: busy all cleared; renames dropped; commits in same cycle STILL write regs (ROB commits
//   the branch itself). No rename after flush until next cycle.
//  Source lookup, slot i, reg r (rs1 and rs2 alike), priority:
//   1 r==0 -> val 0, busy 0.
//   2 highest slot j<i with rn_valid[j], rn_rd[j]==r -> busy 1, tag rn_tag[j] (intra-bundle RAW).
//   3 busy[r] and some commit slot has rd==r, tag==tag[r] -> busy 0, val = that cm_value.
//   4 else busy[r], tag[r]; val = regs[r] (highest commit slot with rd==r overrides).
//   Slot i never sees its own rename or later slots (rs==rd in slot i reads prior mapping).
//  jalr: steps 1,3,4 only (no rename bypass); jalr_busy also 1 if any valid rename targets jalr_rs.
//  All read outputs purely combinational, zero latency; all updates take effect next cycle.
//  Flush cycle: comb outputs unaffected by flush_in (consumers discard).
// TESTING
//  T1 reset, read x1..x31 -> val 0, busy 0; commit x0=5 -> x0 reads 0.
//  T2 rename x5 tag 3; next cycle rs1=x5 -> busy1, tag 3; commit x5 tag3 val 0xAB same cycle -> busy 0
//     val 0xAB; next cycle x5 not busy, val 0xAB.
//  T3 bundle: slot0 rd=x7 tag2, slot1 rs1=x7,rs2=x7 -> slot1 busy, tag 2; slot0 rs1=x7 -> old map.
//  T4 stale commit: x9 renamed tag1 then tag4; commit x9 tag1 val 7 -> regs=7, busy stays, tag 4.
//  T5 rename x3 tag6 and commit x3 tag(old)=6 same cycle -> x3 busy, tag 6; flush next cycle with commit
//     x3 tag6 val 0x11 -> all not busy, x3=0x11, rename same cycle dropped.
//  T6 rdy_in=0 with commit/rename asserted -> no state change; rst_in mid-bundle -> all clear.

Source files
------------

// File: rtl/rf_rename_mp.sv
// Multi-ported architectural register file with an integrated rename table.
// Each register keeps its committed value, a busy bit and the ROB tag of its
// pending producer. NUM_ISSUE rename slots and NUM_COMMIT commit slots are
// serviced per cycle. Source reads are combinational. They see same-cycle
// commits and earlier renames in the same bundle.
module rf_rename_mp #(
   parameter int XLEN          = 32,
   parameter int REG_NUM_WIDTH = 5,
   parameter int TAG_WIDTH     = 4,
   parameter int NUM_ISSUE     = 2,
   parameter int NUM_COMMIT    = 2
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                rdy_in,
   input  logic                                flush_in,
   input  logic [NUM_COMMIT-1:0]               cm_valid,
   input  logic [NUM_COMMIT*REG_NUM_WIDTH-1:0] cm_rd,
   input  logic [NUM_COMMIT*TAG_WIDTH-1:0]     cm_tag,
   input  logic [NUM_COMMIT*XLEN-1:0]          cm_value,
   input  logic [NUM_ISSUE-1:0]                rn_valid,
   input  logic [NUM_ISSUE*REG_NUM_WIDTH-1:0]  rn_rd,
   input  logic [NUM_ISSUE*TAG_WIDTH-1:0]      rn_tag,
   input  logic [NUM_ISSUE*REG_NUM_WIDTH-1:0]  rn_rs1,
   input  logic [NUM_ISSUE*REG_NUM_WIDTH-1:0]  rn_rs2,
   output logic [NUM_ISSUE*XLEN-1:0]           rn_val1,
   output logic [NUM_ISSUE*XLEN-1:0]           rn_val2,
   output logic [NUM_ISSUE-1:0]                rn_busy1,
   output logic [NUM_ISSUE-1:0]                rn_busy2,
   output logic [NUM_ISSUE*TAG_WIDTH-1:0]      rn_tag1,
   output logic [NUM_ISSUE*TAG_WIDTH-1:0]      rn_tag2,
   input  logic [REG_NUM_WIDTH-1:0]            jalr_rs,
   output logic [XLEN-1:0]                     jalr_value,
   output logic                                jalr_busy
);

   localparam int REG_NUM = 1 << REG_NUM_WIDTH;

   typedef logic [REG_NUM_WIDTH-1:0] reg_idx_t;
   typedef logic [TAG_WIDTH-1:0]     tag_t;
   typedef logic [XLEN-1:0]          data_t;

   typedef struct packed {
      data_t val;
      logic  busy;
      tag_t  tag;
   } lookup_t;

   // Architectural state
   data_t r_regs [REG_NUM];
   logic  r_busy [REG_NUM];
   tag_t  r_tag  [REG_NUM];

   // Unpacked views of the flattened slot buses
   reg_idx_t w_cm_rd    [NUM_COMMIT];
   tag_t     w_cm_tag   [NUM_COMMIT];
   data_t    w_cm_value [NUM_COMMIT];
   reg_idx_t w_rn_rd    [NUM_ISSUE];
   tag_t     w_rn_tag   [NUM_ISSUE];
   reg_idx_t w_rn_rs1   [NUM_ISSUE];
   reg_idx_t w_rn_rs2   [NUM_ISSUE];

   for (genvar c = 0; c < NUM_COMMIT; c++) begin : g_cm_unpack
      assign w_cm_rd[c]    = cm_rd[c*REG_NUM_WIDTH +: REG_NUM_WIDTH];
      assign w_cm_tag[c]   = cm_tag[c*TAG_WIDTH +: TAG_WIDTH];
      assign w_cm_value[c] = cm_value[c*XLEN +: XLEN];
   end

   for (genvar i = 0; i < NUM_ISSUE; i++) begin : g_rn_unpack
      assign w_rn_rd[i]  = rn_rd[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
      assign w_rn_tag[i] = rn_tag[i*TAG_WIDTH +: TAG_WIDTH];
      assign w_rn_rs1[i] = rn_rs1[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
      assign w_rn_rs2[i] = rn_rs2[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
   end

   // Lookup against committed state plus same-cycle commits. A commit whose
   // tag matches the current producer resolves the dependency. Any commit to
   // the register still forwards its value, because that value is what the
   // register will hold next cycle. Later commit slots override earlier ones.
   function automatic lookup_t f_state_lookup(input reg_idx_t r);
      lookup_t res;
      res.val  = r_regs[r];
      res.busy = r_busy[r];
      res.tag  = r_tag[r];
      for (int c = 0; c < NUM_COMMIT; c++) begin
         if (cm_valid[c] && w_cm_rd[c] == r) begin
            res.val = w_cm_value[c];
            if (r_busy[r] && w_cm_tag[c] == r_tag[r]) begin
               res.busy = 1'b0;
            end
         end
      end
      if (r == '0) begin
         res = '0;
      end
      return res;
   endfunction

   // Intra-bundle RAW: the youngest older slot that renames r supplies the tag.
   function automatic lookup_t f_rn_bypass(input lookup_t base, input reg_idx_t r,
                                           input int upto);
      lookup_t res;
      res = base;
      for (int j = 0; j < NUM_ISSUE; j++) begin
         if (j < upto && rn_valid[j] && w_rn_rd[j] == r && r != '0) begin
            res.busy = 1'b1;
            res.tag  = w_rn_tag[j];
         end
      end
      return res;
   endfunction

   for (genvar i = 0; i < NUM_ISSUE; i++) begin : g_src
      lookup_t w_src1;
      lookup_t w_src2;

      // Resolve both sources of slot i. Slot i never sees its own rename.
      always_comb begin
         w_src1 = f_rn_bypass(f_state_lookup(w_rn_rs1[i]), w_rn_rs1[i], i);
         w_src2 = f_rn_bypass(f_state_lookup(w_rn_rs2[i]), w_rn_rs2[i], i);
      end

      assign rn_val1[i*XLEN +: XLEN]           = w_src1.val;
      assign rn_val2[i*XLEN +: XLEN]           = w_src2.val;
      assign rn_busy1[i]                       = w_src1.busy;
      assign rn_busy2[i]                       = w_src2.busy;
      assign rn_tag1[i*TAG_WIDTH +: TAG_WIDTH] = w_src1.tag;
      assign rn_tag2[i*TAG_WIDTH +: TAG_WIDTH] = w_src2.tag;
   end

   lookup_t w_jalr;
   logic    w_jalr_rn_hit;

   // jalr base: no rename bypass, but any rename of the base register stalls IF.
   always_comb begin
      w_jalr        = f_state_lookup(jalr_rs);
      w_jalr_rn_hit = 1'b0;
      for (int j = 0; j < NUM_ISSUE; j++) begin
         if (rn_valid[j] && w_rn_rd[j] == jalr_rs && jalr_rs != '0) begin
            w_jalr_rn_hit = 1'b1;
         end
      end
   end

   assign jalr_value = w_jalr.val;
   assign jalr_busy  = w_jalr.busy | w_jalr_rn_hit;

   // State update. Commits write values, even during a flush. A matching
   // commit clears busy, and renames set busy and tag. Because the renames are
   // assigned after the clears, a rename beats a commit-clear on the same
   // register, and the highest slot wins within each group.
   // NOTE: the register array is reset through a loop because reset must
   // leave every architectural value at zero, so it cannot be mapped onto an
   // uninitialised RAM macro.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int r = 0; r < REG_NUM; r++) begin
            r_regs[r] <= '0;
            r_busy[r] <= 1'b0;
            r_tag[r]  <= '0;
         end
      end else if (rdy_in) begin
         for (int c = 0; c < NUM_COMMIT; c++) begin
            if (cm_valid[c] && w_cm_rd[c] != '0) begin
               r_regs[w_cm_rd[c]] <= w_cm_value[c];
            end
         end
         if (flush_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
               r_busy[r] <= 1'b0;
            end
         end else begin
            for (int c = 0; c < NUM_COMMIT; c++) begin
               if (cm_valid[c] && w_cm_rd[c] != '0 && r_busy[w_cm_rd[c]] &&
                   r_tag[w_cm_rd[c]] == w_cm_tag[c]) begin
                  r_busy[w_cm_rd[c]] <= 1'b0;
               end
            end
            for (int i = 0; i < NUM_ISSUE; i++) begin
               if (rn_valid[i] && w_rn_rd[i] != '0) begin
                  r_busy[w_rn_rd[i]] <= 1'b1;
                  r_tag[w_rn_rd[i]]  <= w_rn_tag[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_rename_mp.sv
// Directed testbench for rf_rename_mp. Inputs change 1 ns after the rising
// edge, and combinational outputs are sampled 1 ns later, well away from the
// next edge.
module tb_rf_rename_mp;

   localparam int XLEN = 32;
   localparam int RW   = 5;
   localparam int TW   = 4;
   localparam int NI   = 2;
   localparam int NC   = 2;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              rdy_in;
   logic              flush_in;
   logic [NC-1:0]     cm_valid;
   logic [NC*RW-1:0]  cm_rd;
   logic [NC*TW-1:0]  cm_tag;
   logic [NC*XLEN-1:0] cm_value;
   logic [NI-1:0]     rn_valid;
   logic [NI*RW-1:0]  rn_rd;
   logic [NI*TW-1:0]  rn_tag;
   logic [NI*RW-1:0]  rn_rs1;
   logic [NI*RW-1:0]  rn_rs2;
   logic [NI*XLEN-1:0] rn_val1;
   logic [NI*XLEN-1:0] rn_val2;
   logic [NI-1:0]     rn_busy1;
   logic [NI-1:0]     rn_busy2;
   logic [NI*TW-1:0]  rn_tag1;
   logic [NI*TW-1:0]  rn_tag2;
   logic [RW-1:0]     jalr_rs;
   logic [XLEN-1:0]   jalr_value;
   logic              jalr_busy;

   int n_checks = 0;
   int n_errors = 0;

   rf_rename_mp #(
      .XLEN(XLEN), .REG_NUM_WIDTH(RW), .TAG_WIDTH(TW), .NUM_ISSUE(NI), .NUM_COMMIT(NC)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_value(cm_value),
      .rn_valid(rn_valid), .rn_rd(rn_rd), .rn_tag(rn_tag),
      .rn_rs1(rn_rs1), .rn_rs2(rn_rs2),
      .rn_val1(rn_val1), .rn_val2(rn_val2),
      .rn_busy1(rn_busy1), .rn_busy2(rn_busy2),
      .rn_tag1(rn_tag1), .rn_tag2(rn_tag2),
      .jalr_rs(jalr_rs), .jalr_value(jalr_value), .jalr_busy(jalr_busy)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [XLEN-1:0] val1(input int s);
      return rn_val1[s*XLEN +: XLEN];
   endfunction
   function automatic logic [XLEN-1:0] val2(input int s);
      return rn_val2[s*XLEN +: XLEN];
   endfunction
   function automatic logic [TW-1:0] tag1(input int s);
      return rn_tag1[s*TW +: TW];
   endfunction
   function automatic logic [TW-1:0] tag2(input int s);
      return rn_tag2[s*TW +: TW];
   endfunction

   task automatic idle();
      rst_in   = 1'b0;
      rdy_in   = 1'b1;
      flush_in = 1'b0;
      cm_valid = '0; cm_rd = '0; cm_tag = '0; cm_value = '0;
      rn_valid = '0; rn_rd = '0; rn_tag = '0; rn_rs1 = '0; rn_rs2 = '0;
      jalr_rs  = '0;
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_rn(input int s, input logic [RW-1:0] rd, input logic [TW-1:0] tg);
      rn_valid[s]       = 1'b1;
      rn_rd[s*RW +: RW] = rd;
      rn_tag[s*TW +: TW] = tg;
   endtask

   task automatic set_src(input int s, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
      rn_rs1[s*RW +: RW] = rs1;
      rn_rs2[s*RW +: RW] = rs2;
   endtask

   task automatic set_cm(input int s, input logic [RW-1:0] rd, input logic [TW-1:0] tg,
                         input logic [XLEN-1:0] v);
      cm_valid[s]           = 1'b1;
      cm_rd[s*RW +: RW]     = rd;
      cm_tag[s*TW +: TW]    = tg;
      cm_value[s*XLEN +: XLEN] = v;
   endtask

   task automatic test_reset();
      idle();
      rst_in = 1'b1;
      tick(); tick();
      idle();
      for (int r = 1; r < 32; r++) begin
         set_src(0, RW'(r), RW'(r));
         set_src(1, RW'(r), RW'(r));
         jalr_rs = RW'(r);
         settle();
         n_checks++;
         if (val1(0) !== 32'h0 || rn_busy1[0] !== 1'b0 || val2(1) !== 32'h0 ||
             rn_busy2[1] !== 1'b0 || jalr_value !== 32'h0 || jalr_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_x%0d: got val1=%0h busy1=%0b val2=%0h busy2=%0b jalr=%0h/%0b expected all 0",
                     r, val1(0), rn_busy1[0], val2(1), rn_busy2[1], jalr_value, jalr_busy);
         end
      end
      // A commit to x0 must not stick.
      idle();
      set_cm(0, 5'd0, 4'd0, 32'h5);
      tick();
      idle();
      set_src(0, 5'd0, 5'd0);
      settle();
      n_checks++;
      if (val1(0) !== 32'h0 || rn_busy1[0] !== 1'b0 || jalr_value !== 32'h0) begin
         n_errors++;
         $display("FAIL x0_write: got val=%0h busy=%0b jalr=%0h expected 0/0/0",
                  val1(0), rn_busy1[0], jalr_value);
      end
   endtask

   task automatic test_rename_commit();
      idle();
      set_rn(0, 5'd5, 4'd3);
      tick();
      idle();
      set_src(0, 5'd5, 5'd0);
      jalr_rs = 5'd5;
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b1 || tag1(0) !== 4'd3 || jalr_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL t2_pending: got busy=%0b tag=%0d jalr_busy=%0b expected 1/3/1",
                  rn_busy1[0], tag1(0), jalr_busy);
      end
      set_cm(0, 5'd5, 4'd3, 32'hAB);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b0 || val1(0) !== 32'hAB || jalr_busy !== 1'b0 ||
          jalr_value !== 32'hAB) begin
         n_errors++;
         $display("FAIL t2_bypass: got busy=%0b val=%0h jalr=%0h/%0b expected 0/ab ab/0",
                  rn_busy1[0], val1(0), jalr_value, jalr_busy);
      end
      tick();
      idle();
      set_src(0, 5'd5, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b0 || val1(0) !== 32'hAB) begin
         n_errors++;
         $display("FAIL t2_after: got busy=%0b val=%0h expected 0/ab", rn_busy1[0], val1(0));
      end
   endtask

   task automatic test_bundle();
      idle();
      set_rn(0, 5'd7, 4'd2);
      set_src(0, 5'd7, 5'd0);
      set_src(1, 5'd7, 5'd7);
      jalr_rs = 5'd7;
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b0 || val1(0) !== 32'h0) begin
         n_errors++;
         $display("FAIL t3_slot0_old: got busy=%0b val=%0h expected 0/0", rn_busy1[0], val1(0));
      end
      n_checks++;
      if (rn_busy1[1] !== 1'b1 || tag1(1) !== 4'd2 || rn_busy2[1] !== 1'b1 || tag2(1) !== 4'd2) begin
         n_errors++;
         $display("FAIL t3_slot1_raw: got busy1=%0b tag1=%0d busy2=%0b tag2=%0d expected 1/2/1/2",
                  rn_busy1[1], tag1(1), rn_busy2[1], tag2(1));
      end
      n_checks++;
      if (jalr_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL t3_jalr_stall: got %0b expected 1", jalr_busy);
      end
      tick();
      // Both slots rename x8: slot 1 wins. Slot 1 reads x8 and sees only slot 0.
      idle();
      set_rn(0, 5'd8, 4'd1);
      set_rn(1, 5'd8, 4'd9);
      set_src(0, 5'd7, 5'd0);
      set_src(1, 5'd8, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b1 || tag1(0) !== 4'd2) begin
         n_errors++;
         $display("FAIL t3_x7_state: got busy=%0b tag=%0d expected 1/2", rn_busy1[0], tag1(0));
      end
      n_checks++;
      if (rn_busy1[1] !== 1'b1 || tag1(1) !== 4'd1) begin
         n_errors++;
         $display("FAIL t3_self_excl: got busy=%0b tag=%0d expected 1/1", rn_busy1[1], tag1(1));
      end
      tick();
      idle();
      set_src(0, 5'd8, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b1 || tag1(0) !== 4'd9) begin
         n_errors++;
         $display("FAIL t3_same_rd: got busy=%0b tag=%0d expected 1/9", rn_busy1[0], tag1(0));
      end
   endtask

   task automatic test_stale_commit();
      idle();
      set_rn(0, 5'd9, 4'd1);
      tick();
      idle();
      set_rn(0, 5'd9, 4'd4);
      tick();
      idle();
      set_cm(0, 5'd9, 4'd1, 32'h7);
      set_src(0, 5'd9, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b1 || tag1(0) !== 4'd4 || val1(0) !== 32'h7) begin
         n_errors++;
         $display("FAIL t4_during: got busy=%0b tag=%0d val=%0h expected 1/4/7",
                  rn_busy1[0], tag1(0), val1(0));
      end
      tick();
      idle();
      set_src(0, 5'd9, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b1 || tag1(0) !== 4'd4 || val1(0) !== 32'h7) begin
         n_errors++;
         $display("FAIL t4_after: got busy=%0b tag=%0d val=%0h expected 1/4/7",
                  rn_busy1[0], tag1(0), val1(0));
      end
      // Two commits to x10: the higher slot's value wins.
      idle();
      set_cm(0, 5'd10, 4'd0, 32'h1);
      set_cm(1, 5'd10, 4'd0, 32'h2);
      set_src(0, 5'd10, 5'd0);
      settle();
      n_checks++;
      if (val1(0) !== 32'h2) begin
         n_errors++;
         $display("FAIL t4_dual_cm_fwd: got %0h expected 2", val1(0));
      end
      tick();
      idle();
      set_src(0, 5'd10, 5'd0);
      settle();
      n_checks++;
      if (val1(0) !== 32'h2) begin
         n_errors++;
         $display("FAIL t4_dual_cm_reg: got %0h expected 2", val1(0));
      end
   endtask

   task automatic test_flush();
      idle();
      set_rn(0, 5'd3, 4'd6);
      tick();
      idle();
      set_rn(0, 5'd3, 4'd6);
      set_cm(0, 5'd3, 4'd6, 32'h22);
      set_src(0, 5'd3, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b0 || val1(0) !== 32'h22) begin
         n_errors++;
         $display("FAIL t5_cm_bypass: got busy=%0b val=%0h expected 0/22", rn_busy1[0], val1(0));
      end
      tick();
      idle();
      set_src(0, 5'd3, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b1 || tag1(0) !== 4'd6 || val1(0) !== 32'h22) begin
         n_errors++;
         $display("FAIL t5_rn_beats_cm: got busy=%0b tag=%0d val=%0h expected 1/6/22",
                  rn_busy1[0], tag1(0), val1(0));
      end
      // Flush cycle with a commit and a rename.
      idle();
      flush_in = 1'b1;
      set_cm(0, 5'd3, 4'd6, 32'h11);
      set_rn(0, 5'd4, 4'd5);
      set_src(1, 5'd4, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[1] !== 1'b1 || tag1(1) !== 4'd5) begin
         n_errors++;
         $display("FAIL t5_flush_comb: got busy=%0b tag=%0d expected 1/5", rn_busy1[1], tag1(1));
      end
      tick();
      idle();
      set_src(0, 5'd3, 5'd4);
      set_src(1, 5'd9, 5'd8);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b0 || val1(0) !== 32'h11 || rn_busy2[0] !== 1'b0) begin
         n_errors++;
         $display("FAIL t5_after_flush: got x3 busy=%0b val=%0h x4 busy=%0b expected 0/11/0",
                  rn_busy1[0], val1(0), rn_busy2[0]);
      end
      n_checks++;
      if (rn_busy1[1] !== 1'b0 || val1(1) !== 32'h7 || rn_busy2[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL t5_flush_all: got x9 busy=%0b val=%0h x8 busy=%0b expected 0/7/0",
                  rn_busy1[1], val1(1), rn_busy2[1]);
      end
   endtask

   task automatic test_hold_reset();
      idle();
      set_cm(0, 5'd12, 4'd0, 32'h55);
      tick();
      idle();
      rdy_in = 1'b0;
      set_cm(0, 5'd12, 4'd0, 32'h99);
      set_rn(1, 5'd12, 4'd7);
      tick();
      idle();
      set_src(0, 5'd12, 5'd0);
      settle();
      n_checks++;
      if (rn_busy1[0] !== 1'b0 || val1(0) !== 32'h55) begin
         n_errors++;
         $display("FAIL t6_hold: got busy=%0b val=%0h expected 0/55", rn_busy1[0], val1(0));
      end
      // Reset wins over rdy_in=0 and over the bundle in flight.
      idle();
      rst_in = 1'b1;
      rdy_in = 1'b0;
      set_rn(0, 5'd13, 4'd2);
      set_cm(0, 5'd12, 4'd0, 32'h3);
      tick();
      idle();
      set_src(0, 5'd12, 5'd13);
      set_src(1, 5'd3, 5'd9);
      settle();
      n_checks++;
      if (val1(0) !== 32'h0 || rn_busy2[0] !== 1'b0 || val1(1) !== 32'h0 || val2(1) !== 32'h0) begin
         n_errors++;
         $display("FAIL t6_reset: got x12=%0h x13busy=%0b x3=%0h x9=%0h expected 0/0/0/0",
                  val1(0), rn_busy2[0], val1(1), val2(1));
      end
   endtask

   initial begin
      test_reset();
      test_rename_commit();
      test_bundle();
      test_stale_commit();
      test_flush();
      test_hold_reset();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
